// File: rtl/io_responder.sv
// Peripheral end of the memory-mapped I/O bus: LED register, debounced switch
// register and a registered, single-cycle read-response path.
module io_responder #(
  parameter logic [31:0] LED_ADDR  = 32'hFFFF_FC60,
  parameter logic [31:0] SW_ADDR   = 32'hFFFF_FC70,
  parameter int unsigned DB_CYCLES = 100000,
  parameter int unsigned DB_W      = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_ctrl,
  input  logic        switch_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [15:0] io_read_data,
  output logic        io_ready,
  output logic [15:0] led,
  input  logic [15:0] sw
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [15:0]     r_sw_meta;
  logic [15:0]     r_sw_sync;
  logic [15:0]     r_sw_stable;
  logic [DB_W-1:0] r_db_cnt;
  logic [15:0]     r_led;
  logic [15:0]     r_rd_data;
  logic            r_ready;

  logic            w_led_hit;
  logic            w_sw_hit;
  logic            w_rd_en;
  logic            w_wr_en;
  logic            w_unused;

  assign w_led_hit = (addr == LED_ADDR);
  assign w_sw_hit  = (addr == SW_ADDR);
  assign w_wr_en   = led_ctrl & w_led_hit;
  // A simultaneous write strobe wins: the read is dropped entirely.
  assign w_rd_en   = switch_ctrl & ~led_ctrl;
  assign w_unused  = ^write_data[31:16];

  // Per-bit two-flop synchroniser for the raw switch pins.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sw_meta[gi] <= 1'b0;
          r_sw_sync[gi] <= 1'b0;
        end else begin
          r_sw_meta[gi] <= sw[gi];
          r_sw_sync[gi] <= r_sw_meta[gi];
        end
      end
    end
  endgenerate

  // One counter for the whole bus: any departure from the accepted value must
  // persist DB_CYCLES cycles; the latest synchronised value is what gets taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_stable <= '0;
      r_db_cnt    <= '0;
    end else if (r_sw_sync == r_sw_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_sw_stable <= r_sw_sync;
      r_db_cnt    <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else if (w_wr_en) begin
      r_led <= write_data[15:0];
    end
  end

  // Read data is not held; the consumer samples only while io_ready is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_ready   <= 1'b0;
    end else if (w_rd_en && w_sw_hit) begin
      r_rd_data <= r_sw_stable;
      r_ready   <= 1'b1;
    end else if (w_rd_en && w_led_hit) begin
      r_rd_data <= r_led;
      r_ready   <= 1'b1;
    end else begin
      r_rd_data <= '0;
      r_ready   <= 1'b0;
    end
  end

  assign led          = r_led;
  assign io_read_data = r_rd_data;
  assign io_ready     = r_ready;

endmodule
